// File: rtl/bcd_digit_entry_if.sv
// Keypad-side bundle for bcd_digit_entry: raw key lines and clear in, BCD entry state out.
interface bcd_digit_entry_if #(
    parameter int DIGITS = 4
);
    localparam int CW = $clog2(DIGITS + 1);

    logic [9:0]          key;
    logic                clr;
    logic [4*DIGITS-1:0] digits;
    logic [CW-1:0]       count;
    logic                full;
    logic                key_valid;
    logic                err;

    modport master (
        output key, clr,
        input  digits, count, full, key_valid, err
    );

    modport slave (
        input  key, clr,
        output digits, count, full, key_valid, err
    );
endinterface

// File: rtl/bcd_digit_entry.sv
// Synchronises and debounces a one-hot decimal keypad, encodes accepted keys to BCD and
// shifts them into a DIGITS-wide entry register, flagging multi-hot presses and overflow.
module bcd_digit_entry #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int OVF_MODE      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_digit_entry_if.slave bus
);
    localparam int              CW         = $clog2(DIGITS + 1);
    localparam int              DW         = 4 * DIGITS;
    localparam logic [7:0]      STAB_MAX   = 8'(STABLE_CYCLES);
    localparam logic [CW-1:0]   COUNT_FULL = CW'(DIGITS);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    logic [9:0]    s1_reg, s2_reg, held_reg;
    logic [7:0]    stab_reg, stab_next;
    state_t        state_reg, state_next;
    logic          accept;
    logic          key_onehot;
    logic [3:0]    enc;
    logic [DW-1:0] digits_reg, digits_next, shifted;
    logic [CW-1:0] count_reg, count_next;
    logic          full_reg;
    logic          key_valid_reg, key_valid_next;
    logic          err_reg, err_next;

    // Key lines whose index has bit b set; OR-ing them gives BCD bit b of a one-hot key.
    function automatic logic [9:0] enc_mask(input int b);
        logic [9:0] m;
        for (int i = 0; i < 10; i++) m[i] = ((i >> b) & 1) == 1;
        return m;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_enc
            localparam logic [9:0] MASK = enc_mask(gi);
            assign enc[gi] = |(s2_reg & MASK);
        end
    endgenerate

    assign key_onehot = $onehot(s2_reg);

    generate
        if (DIGITS == 1) begin : g_shift_one
            assign shifted = enc;
        end else begin : g_shift_many
            assign shifted = {digits_reg[DW-5:0], enc};
        end
    endgenerate

    // Synchroniser and stability tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            held_reg <= '0;
            stab_reg <= '0;
        end else begin
            s1_reg   <= bus.key;
            s2_reg   <= s1_reg;
            held_reg <= s2_reg;
            stab_reg <= stab_next;
        end
    end

    always_comb begin
        stab_next = 8'd1;
        if (s2_reg == held_reg) begin
            stab_next = (stab_reg >= STAB_MAX) ? STAB_MAX : stab_reg + 8'd1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (s2_reg != '0) state_next = PRESS;
            PRESS: begin
                if (s2_reg == '0) state_next = IDLE;
                else if (accept)  state_next = HELD;
            end
            HELD:    if (s2_reg == '0) state_next = RELEASE;
            RELEASE: begin
                if (s2_reg != '0)              state_next = HELD;
                else if (stab_next == STAB_MAX) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs. The accepting sample is the one that makes the run STABLE_CYCLES long.
    always_comb begin
        accept = (state_reg == PRESS) && (s2_reg != '0) && (stab_next == STAB_MAX);
    end

    // Entry register update; clr overrides any simultaneous accept.
    always_comb begin
        digits_next    = digits_reg;
        count_next     = count_reg;
        key_valid_next = 1'b0;
        err_next       = 1'b0;
        if (bus.clr) begin
            digits_next = '0;
            count_next  = '0;
        end else if (accept) begin
            if (!key_onehot) begin
                err_next = 1'b1;
            end else if (count_reg < COUNT_FULL) begin
                digits_next    = shifted;
                count_next     = count_reg + 1'b1;
                key_valid_next = 1'b1;
            end else if (OVF_MODE == 1) begin
                digits_next    = shifted;
                key_valid_next = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_reg    <= '0;
            count_reg     <= '0;
            full_reg      <= 1'b0;
            key_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            digits_reg    <= digits_next;
            count_reg     <= count_next;
            full_reg      <= (count_next == COUNT_FULL);
            key_valid_reg <= key_valid_next;
            err_reg       <= err_next;
        end
    end

    assign bus.digits    = digits_reg;
    assign bus.count     = count_reg;
    assign bus.full      = full_reg;
    assign bus.key_valid = key_valid_reg;
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed bench for bcd_digit_entry: two instances (drop / roll-over on overflow) share stimulus.
module tb_bcd_digit_entry;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] key   = '0;
    logic       clr   = 1'b0;

    int total = 0;
    int bad   = 0;
    int kv0 = 0, kv1 = 0, er0 = 0, er1 = 0;

    always #5 clk = ~clk;

    bcd_digit_entry_if #(.DIGITS(4)) bus0 ();
    bcd_digit_entry_if #(.DIGITS(4)) bus1 ();

    assign bus0.key = key;
    assign bus0.clr = clr;
    assign bus1.key = key;
    assign bus1.clr = clr;

    bcd_digit_entry #(.DIGITS(4), .STABLE_CYCLES(4), .OVF_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    bcd_digit_entry #(.DIGITS(4), .STABLE_CYCLES(4), .OVF_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (bus0.key_valid) kv0 <= kv0 + 1;
        if (bus1.key_valid) kv1 <= kv1 + 1;
        if (bus0.err)       er0 <= er0 + 1;
        if (bus1.err)       er1 <= er1 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [9:0] k);
        key = k;
        repeat (8) tick();
        key = '0;
        repeat (8) tick();
        $display("press key=%h -> dut0 digits=%h count=%0d | dut1 digits=%h count=%0d",
                 k, bus0.digits, bus0.count, bus1.digits, bus1.count);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++; if (bus0.digits !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%h exp=0000", bus0.digits); end
        total++; if (bus0.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus0.count); end
        total++; if (bus0.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus0.full); end
        total++; if (bus0.key_valid !== 1'b0 || bus0.err !== 1'b0) begin bad++; $display("FAIL reset_pulses got kv=%b err=%b exp 0/0", bus0.key_valid, bus0.err); end
        total++; if (bus1.digits !== 16'h0000 || bus1.count !== 3'd0) begin bad++; $display("FAIL reset_dut1 got digits=%h count=%0d exp 0000/0", bus1.digits, bus1.count); end
        rst_n = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_press();
        int base_kv;
        int base_er;
        base_kv = kv0;
        base_er = er0;
        key = 10'h080;
        repeat (5) tick();   // just after E0+4
        total++; if (bus0.key_valid !== 1'b0 || bus0.digits !== 16'h0000) begin bad++; $display("FAIL press_early got kv=%b digits=%h exp 0/0000", bus0.key_valid, bus0.digits); end
        tick();              // just after E0+5
        total++; if (bus0.digits !== 16'h0007) begin bad++; $display("FAIL press_digits got=%h exp=0007", bus0.digits); end
        total++; if (bus0.count !== 3'd1) begin bad++; $display("FAIL press_count got=%0d exp=1", bus0.count); end
        total++; if (bus0.key_valid !== 1'b1 || bus0.err !== 1'b0) begin bad++; $display("FAIL press_pulse got kv=%b err=%b exp 1/0", bus0.key_valid, bus0.err); end
        tick();
        total++; if (bus0.key_valid !== 1'b0) begin bad++; $display("FAIL press_pulse_width got kv=%b exp=0", bus0.key_valid); end
        repeat (3) tick();
        key = '0;
        repeat (8) tick();
        total++; if (kv0 - base_kv !== 1 || er0 - base_er !== 0) begin bad++; $display("FAIL press_pulse_count got kv=%0d err=%0d exp 1/0", kv0 - base_kv, er0 - base_er); end
        $display("press key=080 -> digits=%h count=%0d", bus0.digits, bus0.count);
    endtask

    task automatic test_bounce();
        int base_kv;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (bus0.digits !== 16'h0000 || bus0.count !== 3'd0) begin bad++; $display("FAIL clr_plain got digits=%h count=%0d exp 0000/0", bus0.digits, bus0.count); end
        base_kv = kv0;
        for (int i = 0; i < 6; i++) begin
            key = (i % 2 == 0) ? 10'h004 : 10'h000;
            tick();
        end
        key = 10'h004;
        repeat (10) tick();
        total++; if (kv0 - base_kv !== 1 || bus0.digits !== 16'h0002) begin bad++; $display("FAIL bounce_press got kv=%0d digits=%h exp 1/0002", kv0 - base_kv, bus0.digits); end
        for (int i = 0; i < 6; i++) begin
            key = (i % 2 == 0) ? 10'h000 : 10'h004;
            tick();
        end
        key = '0;
        repeat (10) tick();
        total++; if (kv0 - base_kv !== 1 || bus0.digits !== 16'h0002 || bus0.count !== 3'd1) begin bad++; $display("FAIL bounce_release got kv=%0d digits=%h count=%0d exp 1/0002/1", kv0 - base_kv, bus0.digits, bus0.count); end
        $display("bounce key=004 -> digits=%h count=%0d", bus0.digits, bus0.count);
    endtask

    task automatic test_multihot();
        int base_kv;
        int base_er;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        base_kv = kv0;
        base_er = er0;
        key = 10'h009;
        repeat (6) tick();   // just after E0+5
        total++; if (bus0.err !== 1'b1 || bus0.key_valid !== 1'b0) begin bad++; $display("FAIL multihot_pulse got err=%b kv=%b exp 1/0", bus0.err, bus0.key_valid); end
        repeat (2) tick();
        key = '0;
        repeat (8) tick();
        total++; if (er0 - base_er !== 1 || kv0 - base_kv !== 0) begin bad++; $display("FAIL multihot_counts got err=%0d kv=%0d exp 1/0", er0 - base_er, kv0 - base_kv); end
        total++; if (bus0.digits !== 16'h0000 || bus0.count !== 3'd0) begin bad++; $display("FAIL multihot_entry got digits=%h count=%0d exp 0000/0", bus0.digits, bus0.count); end
        $display("multihot key=009 -> err pulses=%0d", er0 - base_er);
    endtask

    task automatic test_overflow();
        int b_kv0, b_kv1, b_er0, b_er1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        press_key(10'h002);
        press_key(10'h004);
        press_key(10'h008);
        press_key(10'h010);
        total++; if (bus0.digits !== 16'h1234 || bus0.count !== 3'd4) begin bad++; $display("FAIL fill_dut0 got digits=%h count=%0d exp 1234/4", bus0.digits, bus0.count); end
        total++; if (bus0.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", bus0.full); end
        total++; if (bus1.digits !== 16'h1234) begin bad++; $display("FAIL fill_dut1 got=%h exp=1234", bus1.digits); end
        b_kv0 = kv0; b_kv1 = kv1; b_er0 = er0; b_er1 = er1;
        press_key(10'h020);
        total++; if (bus0.digits !== 16'h1234 || bus0.count !== 3'd4) begin bad++; $display("FAIL ovf0_entry got digits=%h count=%0d exp 1234/4", bus0.digits, bus0.count); end
        total++; if (er0 - b_er0 !== 1 || kv0 - b_kv0 !== 0) begin bad++; $display("FAIL ovf0_pulses got err=%0d kv=%0d exp 1/0", er0 - b_er0, kv0 - b_kv0); end
        total++; if (bus1.digits !== 16'h2345 || bus1.count !== 3'd4 || bus1.full !== 1'b1) begin bad++; $display("FAIL ovf1_entry got digits=%h count=%0d full=%b exp 2345/4/1", bus1.digits, bus1.count, bus1.full); end
        total++; if (kv1 - b_kv1 !== 1 || er1 - b_er1 !== 0) begin bad++; $display("FAIL ovf1_pulses got kv=%0d err=%0d exp 1/0", kv1 - b_kv1, er1 - b_er1); end
    endtask

    task automatic test_clr_collision();
        int b_kv0;
        b_kv0 = kv0;
        key = 10'h200;
        repeat (5) tick();   // just after E0+4
        clr = 1'b1;
        tick();              // accept edge coincides with clr
        clr = 1'b0;
        total++; if (bus0.digits !== 16'h0000 || bus0.count !== 3'd0 || bus0.full !== 1'b0) begin bad++; $display("FAIL clrhit_dut0 got digits=%h count=%0d full=%b exp 0000/0/0", bus0.digits, bus0.count, bus0.full); end
        total++; if (bus0.key_valid !== 1'b0 || bus0.err !== 1'b0) begin bad++; $display("FAIL clrhit_pulses got kv=%b err=%b exp 0/0", bus0.key_valid, bus0.err); end
        total++; if (bus1.digits !== 16'h0000 || bus1.key_valid !== 1'b0) begin bad++; $display("FAIL clrhit_dut1 got digits=%h kv=%b exp 0000/0", bus1.digits, bus1.key_valid); end
        repeat (4) tick();
        key = '0;
        repeat (8) tick();
        total++; if (kv0 - b_kv0 !== 0) begin bad++; $display("FAIL clrhit_nokv got=%0d exp=0", kv0 - b_kv0); end
        $display("clr collision key=200 -> digits=%h", bus0.digits);
        press_key(10'h008);
        total++; if (bus0.digits !== 16'h0003 || bus0.count !== 3'd1) begin bad++; $display("FAIL after_clr got digits=%h count=%0d exp 0003/1", bus0.digits, bus0.count); end
    endtask

    task automatic test_reset_midway();
        int b_kv0;
        key = 10'h080;
        repeat (3) tick();   // in PRESS
        rst_n = 1'b0;
        #1;
        total++; if (bus0.digits !== 16'h0000 || bus0.count !== 3'd0 || bus0.full !== 1'b0) begin bad++; $display("FAIL rst_press got digits=%h count=%0d full=%b exp 0000/0/0", bus0.digits, bus0.count, bus0.full); end
        tick();
        rst_n = 1'b1;
        b_kv0 = kv0;
        repeat (5) tick();
        total++; if (bus0.key_valid !== 1'b0) begin bad++; $display("FAIL rst_relatency_early got kv=%b exp=0", bus0.key_valid); end
        tick();
        total++; if (bus0.key_valid !== 1'b1 || bus0.digits !== 16'h0007 || bus0.count !== 3'd1) begin bad++; $display("FAIL rst_reaccept got kv=%b digits=%h count=%0d exp 1/0007/1", bus0.key_valid, bus0.digits, bus0.count); end
        repeat (3) tick();   // in HELD
        rst_n = 1'b0;
        #1;
        total++; if (bus0.digits !== 16'h0000 || bus0.count !== 3'd0 || bus0.key_valid !== 1'b0 || bus0.err !== 1'b0) begin bad++; $display("FAIL rst_held got digits=%h count=%0d kv=%b err=%b exp 0000/0/0/0", bus0.digits, bus0.count, bus0.key_valid, bus0.err); end
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        total++; if (bus0.digits !== 16'h0007 || bus0.count !== 3'd1) begin bad++; $display("FAIL rst_held_reaccept got digits=%h count=%0d exp 0007/1", bus0.digits, bus0.count); end
        key = '0;
        repeat (8) tick();
        total++; if (kv0 - b_kv0 !== 2) begin bad++; $display("FAIL rst_kv_count got=%0d exp=2", kv0 - b_kv0); end
        $display("reset midway -> digits=%h count=%0d", bus0.digits, bus0.count);
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_multihot();
        test_overflow();
        test_clr_collision();
        test_reset_midway();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
